axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter ID0, default 4'd0: arid driven for requester 0 (instruction fetch).
REQ-002 Parameter ID1, default 4'd1: arid driven for requester 1 (data access).
REQ-003 Parameter BURST, default 2'b01: value driven on m_arburst (INCR).
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 s0_/s1_arvalid  in  1  requester read request valid.
REQ-007 s0_/s1_arready  out  1  request accepted (one-cycle pulse).
REQ-008 s0_/s1_araddr  in  32  byte address.
REQ-009 s0_/s1_arlen  in  8  beats minus one.
REQ-010 s0_/s1_arsize  in  3  log2 bytes per beat.
REQ-011 s0_/s1_rvalid  out  1  read beat valid to requester.
REQ-012 s0_/s1_rready  in  1  requester accepts beat.
REQ-013 s0_/s1_rdata  out  64  beat data.
REQ-014 s0_/s1_rresp  out  2  beat response.
REQ-015 s0_/s1_rlast  out  1  final beat of burst.
REQ-016 m_arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  AXI AR payload.
REQ-017 m_arvalid  out  1 / m_arready  in  1  AXI AR handshake.
REQ-018 m_rid/rdata/rresp/rlast  in  4/64/2/1  AXI R payload.
REQ-019 m_rvalid  in  1 / m_rready  out  1  AXI R handshake.
REQ-020 err  out  1  one-cycle pulse on protocol mismatch (REQ-031, REQ-032).

Function
REQ-021 FSM states: IDLE, ADDR, DATA; one transaction outstanding at most.
REQ-022 IDLE: if any sN_arvalid, select grant (REQ-040), pulse that sN_arready same cycle, register addr/len/size/ID, go ADDR; else stay.
REQ-023 Non-granted requester's arready SHALL stay 0; its request remains pending, not dropped.
REQ-024 ADDR: m_arvalid=1 with registered payload, stable until m_arready; on handshake go DATA, clear beat counter.
REQ-025 m_arvalid SHALL be asserted exactly one cycle after sN_arready pulse (latency 1).
REQ-026 DATA: granted sN_rvalid=m_rvalid, m_rready=granted sN_rready, rdata passed combinationally; other requester rvalid=0.
REQ-027 m_rready SHALL be 0 outside DATA.
REQ-028 Beat counter (8 bit) increments on each R handshake; sN_rlast=1 when counter equals registered len.
REQ-029 On handshake of beat with counter==len go IDLE; new grant possible in that IDLE cycle's successor (no back-to-back in the same cycle).
REQ-030 sN_rresp=m_rresp unless REQ-031 applies.
REQ-031 m_rid != registered ID on a handshake: beat forwarded with rresp forced 2'b10, err pulses next cycle.
REQ-032 m_rlast disagreeing with counter==len on a handshake: err pulses next cycle; termination follows the counter, not m_rlast.
REQ-033 len=0: single-beat burst, rlast on first beat.

Reset
REQ-034 reset_n low: FSM to IDLE, counter 0, err 0, priority pointer to requester 0, all registered payload 0.
REQ-035 During/after reset every output valid/ready/last = 0, m_arid/araddr/arlen/arsize = 0, m_arburst = BURST.
REQ-036 Reset mid-transaction abandons it; no beats forwarded after reset_n rises until a new grant.

Configuration
REQ-040 ARB_RR_EN defined: round-robin; when both request, grant the one not granted last; pointer updates on each grant.
REQ-041 ARB_RR_EN undefined: fixed priority, requester 1 always wins ties; no priority pointer register.

Verification
REQ-050 Reset, s0 req addr 0x8000_0000 len 3 -> m_arvalid cycle after s0_arready, m_arid 0, 4 beats to s0, s0_rlast on 4th, s1_rvalid 0 throughout.
REQ-051 Both request same cycle, twice in sequence (ARB_RR_EN) -> grant s0 then s1; without macro -> s1 then s1.
REQ-052 m_arready held low 5 cycles -> m_ar payload stable all 5 cycles, no arready pulse to either requester.
REQ-053 s1 len 1, m_rid=4'd3 on beat 0 -> s1_rresp 2'b10 on that beat, err pulse one cycle later, transaction completes after beat 1.
REQ-054 len 3, m_rlast high on beat 1 -> err pulse, burst still ends on beat 3 with s_rlast.
REQ-055 reset_n low during beat 2 of len 7 -> all valids 0 immediately, IDLE after release, next request granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter
// Two-requester AXI read arbiter. Requester 0 is instruction fetch and
// requester 1 is data access. They share one AXI read master. At most one
// read transaction is outstanding at any time.
//
// Build option:
//   ARB_RR_EN  defined   : round-robin on ties (grant the requester not
//                          granted last).
//              undefined : fixed priority (requester 1 wins ties).
//
// Ports:
//   clock, reset_n              clock, async active-low reset
//   sN_arvalid/arready          requester AR handshake (arready = 1-cycle pulse)
//   sN_araddr/arlen/arsize      requester AR payload
//   sN_rvalid/rready            requester R handshake
//   sN_rdata/rresp/rlast        requester R payload
//   m_ar*                       AXI AR channel (registered payload)
//   m_r*                        AXI R channel
//   err                         1-cycle pulse on RID or RLAST mismatch
// -----------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter logic [3:0] ID0   = 4'd0,
  parameter logic [3:0] ID1   = 4'd1,
  parameter logic [1:0] BURST = 2'b01
) (
  input  logic        clock,
  input  logic        reset_n,
  // requester 0
  input  logic        s0_arvalid,
  output logic        s0_arready,
  input  logic [31:0] s0_araddr,
  input  logic [7:0]  s0_arlen,
  input  logic [2:0]  s0_arsize,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  output logic [63:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rlast,
  // requester 1
  input  logic        s1_arvalid,
  output logic        s1_arready,
  input  logic [31:0] s1_araddr,
  input  logic [7:0]  s1_arlen,
  input  logic [2:0]  s1_arsize,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  output logic [63:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rlast,
  // AXI master AR
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  // AXI master R
  input  logic [3:0]  m_rid,
  input  logic [63:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        err
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned IW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q,   sel_d;     // granted requester (0/1)
  logic [AW-1:0]   addr_q,  addr_d;
  logic [LW-1:0]   len_q,   len_d;
  logic [SW-1:0]   size_q,  size_d;
  logic [IW-1:0]   id_q,    id_d;
  logic [LW-1:0]   cnt_q,   cnt_d;     // beat counter
  logic            err_q,   err_d;
  logic            live_q;             // low for the first cycle after reset

`ifdef ARB_RR_EN
  logic            prio_q,  prio_d;    // requester that wins the next tie
`endif

  logic gnt1;
  logic do_grant;
  logic in_data;
  logic r_hs;
  logic last_beat;
  logic id_bad;
  logic [1:0] rresp_fwd;

  // Grant selection: which requester wins when the FSM can accept one
`ifdef ARB_RR_EN
  assign gnt1 = s1_arvalid && (!s0_arvalid || prio_q);
`else
  assign gnt1 = s1_arvalid;
`endif

  assign do_grant  = (state_q == IDLE) && live_q && (s0_arvalid || s1_arvalid);
  assign in_data   = (state_q == DATA);
  assign r_hs      = in_data && m_rvalid && m_rready;
  assign last_beat = (cnt_q == len_q);
  assign id_bad    = (m_rid != id_q);
  assign rresp_fwd = id_bad ? 2'b10 : m_rresp;

  // Next-state and payload capture
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef ARB_RR_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (do_grant) begin
          sel_d   = gnt1;
          addr_d  = gnt1 ? s1_araddr : s0_araddr;
          len_d   = gnt1 ? s1_arlen  : s0_arlen;
          size_d  = gnt1 ? s1_arsize : s0_arsize;
          id_d    = gnt1 ? ID1       : ID0;
          state_d = ADDR;
`ifdef ARB_RR_EN
          prio_d  = !gnt1;
`endif
        end
      end
      ADDR: begin
        if (m_arready) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (r_hs) begin
          cnt_d = cnt_q + LW'(1);
          // Termination follows the counter; a disagreeing RLAST only flags err
          err_d = id_bad || (m_rlast != last_beat);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin pointer, requester 0 favoured out of reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  // Requester AR acceptance pulses in the granting IDLE cycle
  assign s0_arready = do_grant && !gnt1;
  assign s1_arready = do_grant && gnt1;

  // AR channel driven straight from the captured payload
  assign m_arvalid = (state_q == ADDR);
  assign m_arid    = id_q;
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = size_q;
  assign m_arburst = BURST;

  // R channel routed to the granted requester only
  assign m_rready  = in_data && (sel_q ? s1_rready : s0_rready);
  assign s0_rvalid = in_data && !sel_q && m_rvalid;
  assign s1_rvalid = in_data &&  sel_q && m_rvalid;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = rresp_fwd;
  assign s1_rresp  = rresp_fwd;
  assign s0_rlast  = in_data && !sel_q && last_beat;
  assign s1_rlast  = in_data &&  sel_q && last_beat;

  assign err = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed transactions drive the arbiter; expected AR payloads and R beats
// are queued at issue time and popped by independent monitors on handshakes.
// -----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock, reset_n;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
  logic [31:0] s0_araddr;
  logic [7:0]  s0_arlen;
  logic [2:0]  s0_arsize;
  logic [63:0] s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
  logic [31:0] s1_araddr;
  logic [7:0]  s1_arlen;
  logic [2:0]  s1_arsize;
  logic [63:0] s1_rdata;
  logic [1:0]  s1_rresp;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_arready;
  logic [3:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic        err;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  ar_t   arq[$];
  beat_t q0[$];
  beat_t q1[$];

  int total = 0;
  int bad   = 0;

  axi_rd_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // AR monitor
  always @(negedge clock) begin
    if (reset_n && m_arvalid && m_arready) begin
      ar_t e, a;
      a = {m_arid, m_araddr, m_arlen, m_arsize, m_arburst};
      total++;
      if (arq.size() == 0) begin
        bad++;
        $display("FAIL ar_unexpected got=%h expected none", a);
      end else begin
        e = arq.pop_front();
        if (a != e) begin
          bad++;
          $display("FAIL ar_payload got=%h expected=%h", a, e);
        end
      end
    end
  end

  // R beat monitors
  always @(negedge clock) begin
    if (reset_n && s0_rvalid && s0_rready) begin
      beat_t e, a;
      a = {s0_rdata, s0_rresp, s0_rlast};
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL s0_beat_unexpected got=%h expected none", a);
      end else begin
        e = q0.pop_front();
        if (a != e) begin
          bad++;
          $display("FAIL s0_beat got=%h expected=%h", a, e);
        end
      end
    end
    if (reset_n && s1_rvalid && s1_rready) begin
      beat_t e, a;
      a = {s1_rdata, s1_rresp, s1_rlast};
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL s1_beat_unexpected got=%h expected none", a);
      end else begin
        e = q1.pop_front();
        if (a != e) begin
          bad++;
          $display("FAIL s1_beat got=%h expected=%h", a, e);
        end
      end
    end
  end

  // One complete transaction: request(s), grant, AR phase, R beats
  task automatic run_txn(input logic [1:0] mask, input int exp_g,
                         input logic [31:0] a0, input logic [7:0] l0,
                         input logic [31:0] a1, input logic [7:0] l1,
                         input int stall, input int bad_id, input int bad_last,
                         input int abort);
    logic [31:0] ea;
    logic [7:0]  el;
    logic [3:0]  eid;
    logic [2:0]  esz;
    logic [1:0]  gv, egv;
    bit          got;
    int          n;
    beat_t       eb;

    s0_araddr = a0; s0_arlen = l0; s0_arsize = 3'd3; s0_arvalid = mask[0];
    s1_araddr = a1; s1_arlen = l1; s1_arsize = 3'd2; s1_arvalid = mask[1];
    ea  = (exp_g == 1) ? a1 : a0;
    el  = (exp_g == 1) ? l1 : l0;
    eid = (exp_g == 1) ? 4'd1 : 4'd0;
    esz = (exp_g == 1) ? 3'd2 : 3'd3;
    egv = (exp_g == 1) ? 2'b10 : 2'b01;

    got = 1'b0;
    gv  = 2'b00;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (s0_arready || s1_arready) begin
        got = 1'b1;
        gv  = {s1_arready, s0_arready};
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL grant_timeout got=none expected=%b", egv);
      s0_arvalid = 1'b0;
      s1_arvalid = 1'b0;
      return;
    end
    if (gv != egv) begin
      bad++;
      $display("FAIL grant got=%b expected=%b", gv, egv);
    end
    arq.push_back({eid, ea, el, esz, 2'b01});
    @(posedge clock); #1;
    if (exp_g == 1) s1_arvalid = 1'b0;
    else            s0_arvalid = 1'b0;

    // AR held without m_arready: payload must be valid and stable
    n = (stall < 1) ? 1 : stall;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      total++;
      if (!(m_arvalid && m_araddr == ea && m_arlen == el && m_arid == eid &&
            m_arsize == esz && !s0_arready && !s1_arready)) begin
        bad++;
        $display("FAIL ar_hold cyc=%0d got v=%b id=%h a=%h l=%h rdy=%b%b expected v=1 id=%h a=%h l=%h rdy=00",
                 k, m_arvalid, m_arid, m_araddr, m_arlen, s1_arready, s0_arready, eid, ea, el);
      end
      @(posedge clock); #1;
    end
    m_arready = 1'b1;
    @(posedge clock); #1;
    m_arready = 1'b0;

    for (int b = 0; b <= int'(el); b++) begin
      m_rid   = (b == bad_id) ? 4'd3 : eid;
      m_rlast = ((b == int'(el)) != (b == bad_last));
      m_rdata = {ea, 32'(b)};
      m_rresp = 2'(b & 1);
      if (b == abort) begin
        m_rvalid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (s0_rvalid || s1_rvalid || m_rready || m_arvalid || s0_arready ||
            s1_arready || s0_rlast || s1_rlast || err) begin
          bad++;
          $display("FAIL reset_abort got rv=%b%b mrr=%b arv=%b last=%b%b err=%b expected all 0",
                   s1_rvalid, s0_rvalid, m_rready, m_arvalid, s1_rlast, s0_rlast, err);
        end
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        // Stale R data after release must not reach either requester
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          total++;
          if (s0_rvalid || s1_rvalid || m_rready) begin
            bad++;
            $display("FAIL post_reset_beat got rv=%b%b mrr=%b expected 000",
                     s1_rvalid, s0_rvalid, m_rready);
          end
        end
        @(posedge clock); #1;
        m_rvalid = 1'b0;
        return;
      end
      eb.data = {ea, 32'(b)};
      eb.resp = (b == bad_id) ? 2'b10 : 2'(b & 1);
      eb.last = (b == int'(el));
      if (exp_g == 1) q1.push_back(eb);
      else            q0.push_back(eb);
      m_rvalid = 1'b1;
      @(posedge clock); #1;
      m_rvalid = 1'b0;
      if (b == int'(el)) begin
        s0_arvalid = 1'b0;
        s1_arvalid = 1'b0;
      end
      @(negedge clock);
      total++;
      if (err != ((b == bad_id) || (b == bad_last))) begin
        bad++;
        $display("FAIL err_pulse beat=%0d got=%b expected=%b", b, err,
                 (b == bad_id) || (b == bad_last));
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    s0_arvalid = 1'b0; s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_rready = 1'b1;
    s1_arvalid = 1'b0; s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_rready = 1'b1;
    m_arready  = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

    repeat (3) @(negedge clock);
    total++;
    if (m_arvalid || s0_arready || s1_arready || s0_rvalid || s1_rvalid ||
        s0_rlast || s1_rlast || m_rready || err || m_arid != 4'd0 ||
        m_araddr != 32'd0 || m_arlen != 8'd0 || m_arsize != 3'd0 || m_arburst != 2'b01) begin
      bad++;
      $display("FAIL reset_state got arv=%b id=%h a=%h l=%h s=%h bu=%b mrr=%b err=%b expected zeros burst=01",
               m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready, err);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Simultaneous requests, twice
    run_txn(2'b11, RR ? 0 : 1, 32'h1000_0000, 8'd1, 32'h2000_0000, 8'd2, 0, -1, -1, -1);
    run_txn(2'b11, 1,          32'h1000_0100, 8'd0, 32'h2000_0100, 8'd1, 0, -1, -1, -1);
    // AR stalled five cycles
    run_txn(2'b01, 0, 32'h3000_0000, 8'd2, 32'h0, 8'd0, 5, -1, -1, -1);
    // Wrong RID on beat 0 of a two-beat burst
    run_txn(2'b10, 1, 32'h0, 8'd0, 32'h4000_0040, 8'd1, 0, 0, -1, -1);
    // Early RLAST on beat 1 of four
    run_txn(2'b01, 0, 32'h5000_0000, 8'd3, 32'h0, 8'd0, 0, -1, 1, -1);
    // Reset during beat 2 of eight
    run_txn(2'b10, 1, 32'h0, 8'd0, 32'h6000_0000, 8'd7, 0, -1, -1, 2);
    // Basic four-beat read after reset
    run_txn(2'b01, 0, 32'h8000_0000, 8'd3, 32'h0, 8'd0, 0, -1, -1, -1);
    // Single-beat burst
    run_txn(2'b01, 0, 32'h9000_0008, 8'd0, 32'h0, 8'd0, 0, -1, -1, -1);
    // Ties after two s0 grants
    run_txn(2'b11, 1,          32'hA000_0000, 8'd1, 32'hB000_0000, 8'd0, 0, -1, -1, -1);
    run_txn(2'b11, RR ? 0 : 1, 32'hA000_0100, 8'd0, 32'hB000_0100, 8'd1, 0, -1, -1, -1);

    repeat (4) @(posedge clock);
    #1;
    total++;
    if (arq.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL leftover got ar=%0d s0=%0d s1=%0d expected 0 0 0",
               arq.size(), q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
